cr16_control_fsm: RTL and testbench
===================================

# cr16_control_fsm

Multi-cycle control unit sitting directly upstream of `cr16_datapath`. It accepts 16-bit CR16 instruction words over a valid/ready handshake and decodes them into the datapath's control inputs: register A/B selects, ALU opcode, immediate and immediate-select, one-hot register write-enable and global enable. It sequences each instruction through fetch, decode and execute, optionally captures status flags on compares, and counts retired instructions.

## Interface
- No parameters; widths are fixed by `cr16_pkg`.
- `I_CLK` in 1: system clock; everything is rising-edge.
- `I_RESET` in 1: one clock; reset is synchronous and active-high.
- `I_INSTR` in 16: instruction word; sampled when `I_INSTR_VALID && O_INSTR_READY`.
- `I_INSTR_VALID` in 1: instruction source has a word.
- `O_INSTR_READY` out 1: FSM is in FETCH.
- `I_STATUS_FLAGS` in 5: datapath `O_STATUS_FLAGS`.
- `O_REG_A_SELECT` out 4: goes to datapath `I_REG_A_SELECT`.
- `O_REG_B_SELECT` out 4: goes to datapath `I_REG_B_SELECT`.
- `O_OPCODE` out 4: datapath ALU opcode.
- `O_IMMEDIATE` out 16: sign-extended imm8.
- `O_IMMEDIATE_SELECT` out 1: selects the immediate in place of the B operand.
- `O_ENABLE` out 1: datapath global enable.
- `O_REG_WRITE_ENABLE` out 16: one-hot write-enable for Rdest.
- `O_FLAGS` out 5: captured compare flags.
- `O_ILLEGAL` out 1: one-cycle pulse on an undecodable instruction.
- `O_RETIRED` out 16: count of retired legal instructions.

## Operation
- **Instruction encoding**
  - `[15:12]` is the major op. `[11:8]` is Rdest. `[7:4]` is the ext field (R-type) or `imm[7:4]`. `[3:0]` is Rsrc (R-type) or `imm[3:0]`.
  - R-type (major `4'h0`), by ext:
    - ADD `5` → ALU `0000`
    - SUB `9` → `0100`
    - CMP `B` → `0100`, no write
    - AND `1` → `0110`
    - OR `2` → `0111`
    - XOR `3` → `1000`
  - R-type operands: A=Rdest, B=Rsrc, `O_IMMEDIATE_SELECT`=0.
  - I-type majors, same ALU mapping: ADDI `5`, SUBI `9`, CMPI `B`, ANDI `1`, ORI `2`, XORI `3`.
  - I-type operands: A=Rdest, `O_IMMEDIATE`={{8{imm[7]}},imm}, `O_IMMEDIATE_SELECT`=1, B select=0.
  - Any other major, or an unlisted R-type ext, is illegal.
- **States:** FETCH → DECODE → EXEC → FETCH.
  - FETCH:
    - `O_INSTR_READY`=1.
    - On handshake, latch IR and go to DECODE; otherwise stay.
  - DECODE:
    - Register all selects, opcode and immediate from IR; they hold through EXEC.
    - `O_ENABLE`=0 and `O_REG_WRITE_ENABLE`=0.
  - EXEC:
    - `O_ENABLE`=1.
    - Legal non-compare: `O_REG_WRITE_ENABLE`=1<<Rdest.
    - CMP/CMPI: no write-enable.
    - Illegal: `O_ILLEGAL`=1, no write-enable, `O_ENABLE`=0.
    - Always return to FETCH.
- **Retired counter:** `O_RETIRED` increments in EXEC for every legal instruction, compares included. Wraps `0xFFFF` → `0x0000`.
- **Handshake:** `I_INSTR_VALID` outside FETCH is ignored; the source must hold the word until ready.
- **Reset:** synchronous and overrides everything, including mid-EXEC.

## Timing
- Reset values:
  - state=FETCH and IR=0.
  - All select/opcode/immediate outputs 0.
  - `O_ENABLE`, `O_IMMEDIATE_SELECT`, `O_REG_WRITE_ENABLE`, `O_ILLEGAL`, `O_FLAGS` and `O_RETIRED` all 0.
  - `O_INSTR_READY` is forced 0 while `I_RESET`=1 and reads 1 in the first cycle after release.
- Handshake at edge N:
  - Decoded controls are valid from cycle N+1.
  - The write-enable pulse lasts exactly cycle N+2 only.
  - Ready rises again in cycle N+3.
- Throughput: one instruction per 3 cycles.
- `O_ILLEGAL` pulses in the same cycle the write-enable would have occurred.
- `O_FLAGS` updates at the end of the compare's EXEC cycle.
- Reset asserted at the edge that ends DECODE: the write-enable never pulses and the counter does not increment.

## Configuration
- Macro: `CR16_CTRL_FLAG_CAPTURE_EN`.
- Defined:
  - CMP/CMPI sample `I_STATUS_FLAGS` into `O_FLAGS` at the end of EXEC.
  - Other instructions leave `O_FLAGS` unchanged.
- Undefined:
  - `O_FLAGS` is tied to 0.
  - CMP/CMPI still decode as legal, retire and count, with no write.

## Structure
- `cr16_pkg` holds:
  - the state enum;
  - major-op, R-type ext and datapath ALU opcode localparams;
  - the instruction field bit positions.
- Sub-module `cr16_instr_decoder`: purely combinational, IR → {selects, opcode, immediate, imm_sel, is_cmp, illegal}.
- `cr16_control_fsm` owns the state register, IR, output registers, flag register and counter.

## Test plan
- ADDI R3,#-2 (`0x53FE`) → DECODE: A=3, opcode `0000`, imm `0xFFFE`, imm_sel=1. EXEC: write-enable `0x0008` for one cycle. `O_RETIRED`=1.
- AND R2,R1 (`0x0211`) → A=2, B=1, opcode `0110`, imm_sel=0, write-enable `0x0004`.
- CMP R4,R5 (`0x04B5`) with `I_STATUS_FLAGS`=`5'b10010` → write-enable stays 0. `O_FLAGS`=`5'b10010` with the macro, 0 without. Counter increments.
- Illegal `0xF000` → `O_ILLEGAL` is high for one cycle at accept+2. Write-enable and `O_ENABLE` stay 0. Counter unchanged. Ready returns at accept+3.
- Back-to-back valid held continuously with `0x0211` then `0x53FE` → accepts are 3 cycles apart. Write-enables `0x0004` then `0x0008` are 3 cycles apart.
- Reset asserted during EXEC of `0x0211` → next cycle write-enable=0, state=FETCH, `O_RETIRED`=0, `O_FLAGS`=0. Ready is 1 the cycle after reset drops.

Source files
------------

// File: rtl/cr16_pkg.sv
// Shared types, encodings and field positions for the CR16 control unit.
package cr16_pkg;

  localparam int INSTR_W = 16;
  localparam int SEL_W   = 4;
  localparam int FLAG_W  = 5;
  localparam int NREGS   = 16;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2
  } state_e;

  localparam int MAJ_MSB = 15;
  localparam int MAJ_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int EXT_MSB = 7;
  localparam int EXT_LSB = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 0;

  localparam logic [3:0] MAJ_RTYPE = 4'h0;

  // R-type ext codes double as I-type major codes
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_OR  = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1000;

  typedef struct packed {
    logic [SEL_W-1:0]   a_sel;
    logic [SEL_W-1:0]   b_sel;
    logic [3:0]         opcode;
    logic [INSTR_W-1:0] imm;
    logic               imm_sel;
    logic               is_cmp;
    logic               illegal;
  } dec_t;

  // Returns {legal, alu_opcode} for an ext / I-type major code.
  function automatic logic [4:0] alu_map(input logic [3:0] op);
    case (op)
      OP_ADD:  alu_map = {1'b1, ALU_ADD};
      OP_SUB:  alu_map = {1'b1, ALU_SUB};
      OP_CMP:  alu_map = {1'b1, ALU_SUB};
      OP_AND:  alu_map = {1'b1, ALU_AND};
      OP_OR:   alu_map = {1'b1, ALU_OR};
      OP_XOR:  alu_map = {1'b1, ALU_XOR};
      default: alu_map = 5'b0_0000;
    endcase
  endfunction

endpackage

// File: rtl/cr16_control_fsm_if.sv
// Instruction handshake and datapath control bundle of the CR16 control unit.
interface cr16_control_fsm_if;
  import cr16_pkg::*;

  logic [INSTR_W-1:0] I_INSTR;
  logic               I_INSTR_VALID;
  logic               O_INSTR_READY;
  logic [FLAG_W-1:0]  I_STATUS_FLAGS;
  logic [SEL_W-1:0]   O_REG_A_SELECT;
  logic [SEL_W-1:0]   O_REG_B_SELECT;
  logic [3:0]         O_OPCODE;
  logic [INSTR_W-1:0] O_IMMEDIATE;
  logic               O_IMMEDIATE_SELECT;
  logic               O_ENABLE;
  logic [NREGS-1:0]   O_REG_WRITE_ENABLE;
  logic [FLAG_W-1:0]  O_FLAGS;
  logic               O_ILLEGAL;
  logic [15:0]        O_RETIRED;

  modport master (
    input  I_INSTR, I_INSTR_VALID, I_STATUS_FLAGS,
    output O_INSTR_READY, O_REG_A_SELECT, O_REG_B_SELECT, O_OPCODE,
           O_IMMEDIATE, O_IMMEDIATE_SELECT, O_ENABLE, O_REG_WRITE_ENABLE,
           O_FLAGS, O_ILLEGAL, O_RETIRED
  );

  modport slave (
    output I_INSTR, I_INSTR_VALID, I_STATUS_FLAGS,
    input  O_INSTR_READY, O_REG_A_SELECT, O_REG_B_SELECT, O_OPCODE,
           O_IMMEDIATE, O_IMMEDIATE_SELECT, O_ENABLE, O_REG_WRITE_ENABLE,
           O_FLAGS, O_ILLEGAL, O_RETIRED
  );
endinterface

// File: rtl/cr16_instr_decoder.sv
// Combinational CR16 instruction decode: word -> selects, ALU op, immediate, flags.
module cr16_instr_decoder
  import cr16_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output dec_t               dec_o
);

  logic [3:0] major, ext, op;
  logic [4:0] m;

  assign major = instr_i[MAJ_MSB:MAJ_LSB];
  assign ext   = instr_i[EXT_MSB:EXT_LSB];
  assign op    = (major == MAJ_RTYPE) ? ext : major;
  assign m     = alu_map(op);

  always_comb begin
    dec_o = '0;
    if (!m[4]) begin
      dec_o.illegal = 1'b1;
    end else begin
      dec_o.a_sel  = instr_i[RD_MSB:RD_LSB];
      dec_o.opcode = m[3:0];
      dec_o.is_cmp = (op == OP_CMP);
      if (major == MAJ_RTYPE) begin
        dec_o.b_sel = instr_i[RS_MSB:RS_LSB];
      end else begin
        dec_o.imm     = {{8{instr_i[7]}}, instr_i[7:0]};
        dec_o.imm_sel = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cr16_control_fsm.sv
// CR16 fetch/decode/execute control unit. Compare flag capture is enabled by
// defining CR16_CTRL_FLAG_CAPTURE_EN; otherwise O_FLAGS is tied to zero.
module cr16_control_fsm
  import cr16_pkg::*;
(
  input  logic               I_CLK,
  input  logic               I_RESET,
  cr16_control_fsm_if.master bus
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  dec_t               dec_q, dec;
  logic [15:0]        retired_q;
  logic               ready, hs;

  // Decode straight from the bus in FETCH so controls are valid in DECODE.
  cr16_instr_decoder u_dec (
    .instr_i (state_q == ST_FETCH ? bus.I_INSTR : ir_q),
    .dec_o   (dec)
  );

  assign hs = ready && bus.I_INSTR_VALID;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) state_q <= ST_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (hs) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    ready                  = 1'b0;
    bus.O_ENABLE           = 1'b0;
    bus.O_REG_WRITE_ENABLE = '0;
    bus.O_ILLEGAL          = 1'b0;
    case (state_q)
      ST_FETCH: ready = !I_RESET;
      ST_EXEC: begin
        if (dec_q.illegal) begin
          bus.O_ILLEGAL = 1'b1;
        end else begin
          bus.O_ENABLE = 1'b1;
          if (!dec_q.is_cmp) bus.O_REG_WRITE_ENABLE = 16'h0001 << dec_q.a_sel;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      ir_q      <= '0;
      dec_q     <= '0;
      retired_q <= '0;
    end else begin
      if (hs) ir_q <= bus.I_INSTR;
      if (hs || state_q == ST_DECODE) dec_q <= dec;
      if (state_q == ST_EXEC && !dec_q.illegal) retired_q <= retired_q + 16'd1;
    end
  end

`ifdef CR16_CTRL_FLAG_CAPTURE_EN
  logic [FLAG_W-1:0] flags_q;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) flags_q <= '0;
    else if (state_q == ST_EXEC && !dec_q.illegal && dec_q.is_cmp)
      flags_q <= bus.I_STATUS_FLAGS;
  end

  assign bus.O_FLAGS = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^bus.I_STATUS_FLAGS;
  assign bus.O_FLAGS  = '0;
`endif

  assign bus.O_INSTR_READY      = ready;
  assign bus.O_REG_A_SELECT     = dec_q.a_sel;
  assign bus.O_REG_B_SELECT     = dec_q.b_sel;
  assign bus.O_OPCODE           = dec_q.opcode;
  assign bus.O_IMMEDIATE        = dec_q.imm;
  assign bus.O_IMMEDIATE_SELECT = dec_q.imm_sel;
  assign bus.O_RETIRED          = retired_q;

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Directed self-checking bench for cr16_control_fsm; checks sampled on falling edges.
module tb_cr16_control_fsm;

  logic I_CLK = 1'b0;
  logic I_RESET;
  int   tests = 0;
  int   fails = 0;

`ifdef CR16_CTRL_FLAG_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  cr16_control_fsm_if bus ();

  cr16_control_fsm dut (
    .I_CLK   (I_CLK),
    .I_RESET (I_RESET),
    .bus     (bus)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge I_CLK);
  endtask

  // Present a word for one FETCH edge; returns in the DECODE cycle.
  task automatic issue(input logic [15:0] w);
    bus.I_INSTR       = w;
    bus.I_INSTR_VALID = 1'b1;
    tick();
    bus.I_INSTR_VALID = 1'b0;
  endtask

  initial begin
    I_RESET            = 1'b1;
    bus.I_INSTR        = '0;
    bus.I_INSTR_VALID  = 1'b0;
    bus.I_STATUS_FLAGS = '0;
    tick();
    tick();
    chk("rst_ready_low", {15'd0, bus.O_INSTR_READY}, 16'd0);
    I_RESET = 1'b0;
    #1;
    chk("rst_ready_rel", {15'd0, bus.O_INSTR_READY}, 16'd1);
    chk("rst_we",        bus.O_REG_WRITE_ENABLE, 16'h0000);
    chk("rst_en",        {15'd0, bus.O_ENABLE}, 16'd0);
    chk("rst_retired",   bus.O_RETIRED, 16'd0);
    chk("rst_flags",     {11'd0, bus.O_FLAGS}, 16'd0);
    chk("rst_imm",       bus.O_IMMEDIATE, 16'd0);
    chk("rst_ctl",       {bus.O_REG_A_SELECT, bus.O_REG_B_SELECT, bus.O_OPCODE,
                          3'd0, bus.O_IMMEDIATE_SELECT}, 16'd0);
    tick();

    // ADDI R3,#-2
    issue(16'h53FE);
    chk("addi_a",     {12'd0, bus.O_REG_A_SELECT}, 16'd3);
    chk("addi_op",    {12'd0, bus.O_OPCODE}, 16'h0);
    chk("addi_imm",   bus.O_IMMEDIATE, 16'hFFFE);
    chk("addi_isel",  {15'd0, bus.O_IMMEDIATE_SELECT}, 16'd1);
    chk("addi_dec_we", bus.O_REG_WRITE_ENABLE, 16'h0000);
    chk("addi_dec_en", {15'd0, bus.O_ENABLE}, 16'd0);
    chk("addi_dec_rdy", {15'd0, bus.O_INSTR_READY}, 16'd0);
    tick();
    chk("addi_we",    bus.O_REG_WRITE_ENABLE, 16'h0008);
    chk("addi_en",    {15'd0, bus.O_ENABLE}, 16'd1);
    tick();
    chk("addi_we_off", bus.O_REG_WRITE_ENABLE, 16'h0000);
    chk("addi_ret",   bus.O_RETIRED, 16'd1);
    chk("addi_rdy",   {15'd0, bus.O_INSTR_READY}, 16'd1);

    // AND R2,R1
    issue(16'h0211);
    chk("and_sel",    {8'd0, bus.O_REG_A_SELECT, bus.O_REG_B_SELECT}, 16'h0021);
    chk("and_op",     {12'd0, bus.O_OPCODE}, 16'h6);
    chk("and_isel",   {15'd0, bus.O_IMMEDIATE_SELECT}, 16'd0);
    tick();
    chk("and_we",     bus.O_REG_WRITE_ENABLE, 16'h0004);
    tick();
    chk("and_ret",    bus.O_RETIRED, 16'd2);

    // CMP R4,R5 with flags 10010
    bus.I_STATUS_FLAGS = 5'b10010;
    issue(16'h04B5);
    chk("cmp_sel",    {8'd0, bus.O_REG_A_SELECT, bus.O_REG_B_SELECT}, 16'h0045);
    chk("cmp_op",     {12'd0, bus.O_OPCODE}, 16'h4);
    tick();
    chk("cmp_we",     bus.O_REG_WRITE_ENABLE, 16'h0000);
    chk("cmp_en",     {15'd0, bus.O_ENABLE}, 16'd1);
    chk("cmp_flg_pre", {11'd0, bus.O_FLAGS}, 16'd0);
    tick();
    chk("cmp_flags",  {11'd0, bus.O_FLAGS}, CAP ? 16'h0012 : 16'h0000);
    chk("cmp_ret",    bus.O_RETIRED, 16'd3);

    // CMPI R4,#0x7F with flags 01101
    bus.I_STATUS_FLAGS = 5'b01101;
    issue(16'hB47F);
    chk("cmpi_imm",   bus.O_IMMEDIATE, 16'h007F);
    chk("cmpi_ctl",   {bus.O_REG_A_SELECT, bus.O_REG_B_SELECT, bus.O_OPCODE,
                       3'd0, bus.O_IMMEDIATE_SELECT}, 16'h4041);
    tick();
    chk("cmpi_we",    bus.O_REG_WRITE_ENABLE, 16'h0000);
    tick();
    chk("cmpi_flags", {11'd0, bus.O_FLAGS}, CAP ? 16'h000D : 16'h0000);
    chk("cmpi_ret",   bus.O_RETIRED, 16'd4);

    // Illegal major: flags must survive
    bus.I_STATUS_FLAGS = 5'b11111;
    issue(16'hF000);
    chk("ill_dec",    {15'd0, bus.O_ILLEGAL}, 16'd0);
    tick();
    chk("ill_pulse",  {15'd0, bus.O_ILLEGAL}, 16'd1);
    chk("ill_we",     bus.O_REG_WRITE_ENABLE, 16'h0000);
    chk("ill_en",     {15'd0, bus.O_ENABLE}, 16'd0);
    chk("ill_rdy_x",  {15'd0, bus.O_INSTR_READY}, 16'd0);
    tick();
    chk("ill_off",    {15'd0, bus.O_ILLEGAL}, 16'd0);
    chk("ill_rdy",    {15'd0, bus.O_INSTR_READY}, 16'd1);
    chk("ill_ret",    bus.O_RETIRED, 16'd4);
    chk("ill_flags",  {11'd0, bus.O_FLAGS}, CAP ? 16'h000D : 16'h0000);

    // Illegal R-type ext 4
    issue(16'h0240);
    tick();
    chk("ext_ill",    {15'd0, bus.O_ILLEGAL}, 16'd1);
    chk("ext_we",     bus.O_REG_WRITE_ENABLE, 16'h0000);
    tick();
    chk("ext_ret",    bus.O_RETIRED, 16'd4);

    // Back-to-back with valid held: accepts and write-enables 3 cycles apart
    bus.I_INSTR       = 16'h0211;
    bus.I_INSTR_VALID = 1'b1;
    tick();
    chk("b2b_dec_rdy", {15'd0, bus.O_INSTR_READY}, 16'd0);
    tick();
    chk("b2b_we1",    bus.O_REG_WRITE_ENABLE, 16'h0004);
    bus.I_INSTR = 16'h53FE;
    tick();
    chk("b2b_rdy",    {15'd0, bus.O_INSTR_READY}, 16'd1);
    chk("b2b_gap",    bus.O_REG_WRITE_ENABLE, 16'h0000);
    tick();
    bus.I_INSTR_VALID = 1'b0;
    chk("b2b_a2",     {12'd0, bus.O_REG_A_SELECT}, 16'd3);
    tick();
    chk("b2b_we2",    bus.O_REG_WRITE_ENABLE, 16'h0008);
    tick();
    chk("b2b_ret",    bus.O_RETIRED, 16'd6);

    // Reset during EXEC
    issue(16'h0211);
    tick();
    chk("rx_we",      bus.O_REG_WRITE_ENABLE, 16'h0004);
    I_RESET = 1'b1;
    #1;
    chk("rx_rdy_frc", {15'd0, bus.O_INSTR_READY}, 16'd0);
    tick();
    chk("rx_we_off",  bus.O_REG_WRITE_ENABLE, 16'h0000);
    chk("rx_ret",     bus.O_RETIRED, 16'd0);
    chk("rx_flags",   {11'd0, bus.O_FLAGS}, 16'd0);
    chk("rx_sel",     {12'd0, bus.O_REG_A_SELECT}, 16'd0);
    I_RESET = 1'b0;
    #1;
    chk("rx_rdy",     {15'd0, bus.O_INSTR_READY}, 16'd1);
    tick();

    // Reset at the edge ending DECODE: no write-enable, no retire
    issue(16'h0211);
    I_RESET = 1'b1;
    tick();
    chk("rd_we",      bus.O_REG_WRITE_ENABLE, 16'h0000);
    chk("rd_en",      {15'd0, bus.O_ENABLE}, 16'd0);
    I_RESET = 1'b0;
    tick();
    chk("rd_we2",     bus.O_REG_WRITE_ENABLE, 16'h0000);
    chk("rd_ret",     bus.O_RETIRED, 16'd0);
    chk("rd_rdy",     {15'd0, bus.O_INSTR_READY}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
